// File: rtl/sam_pkg.sv
// Shared SAM CPU definitions: memory geometry defaults and arbiter
// state/owner encodings used by the datapath and the memory arbiter.
package sam_pkg;

    localparam int SAM_ADDR_W = 12;
    localparam int SAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        IO_ACC,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU,
        OWNER_IO
    } owner_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the SAM memory port between the CPU
// controller and the I/O-DMA requester, with fixed-latency sequencing.
module mem_bus_arbiter
    import sam_pkg::*;
#(
    parameter int ADDR_W  = SAM_ADDR_W,
    parameter int DATA_W  = SAM_DATA_W,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              wait_,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_done,
    output logic [DATA_W-1:0] io_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    owner_t           last;
    logic [CNT_W-1:0] cnt;
    logic             cpu_ack;

    logic             grant_cpu;
    logic             grant_io;
    logic             acc_end;

    // A stale ack register must not release the controller while reset is held.
    assign wait_ = cpu_req & ~(cpu_ack & ~reset);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_cpu  = 1'b0;
        grant_io   = 1'b0;
        acc_end    = 1'b0;

        unique case (state)
            IDLE: begin
                if (cpu_req && (!io_req || last == OWNER_IO)) begin
                    grant_cpu  = 1'b1;
                    state_next = CPU_ACC;
                end else if (io_req) begin
                    grant_io   = 1'b1;
                    state_next = IO_ACC;
                end
            end
            CPU_ACC, IO_ACC: begin
                if (cnt == '0) begin
                    acc_end    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= OWNER_IO;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            io_rdata  <= '0;
            io_gnt    <= 1'b0;
            io_done   <= 1'b0;
            cpu_ack   <= 1'b0;
        end else begin
            cpu_ack <= acc_end && (state == CPU_ACC);
            io_done <= acc_end && (state == IO_ACC);

            if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_we    <= cpu_we;
                mem_en    <= 1'b1;
                cnt       <= CNT_LOAD;
                last      <= OWNER_CPU;
            end

            if (grant_io) begin
                mem_addr  <= io_addr;
                mem_wdata <= io_wdata;
                mem_we    <= io_we;
                mem_en    <= 1'b1;
                io_gnt    <= 1'b1;
                cnt       <= CNT_LOAD;
                last      <= OWNER_IO;
            end

            if ((state == CPU_ACC || state == IO_ACC) && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (acc_end) begin
                if (!mem_we) begin
                    if (state == CPU_ACC) begin
                        cpu_rdata <= mem_rdata;
                    end else begin
                        io_rdata <= mem_rdata;
                    end
                end
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                io_gnt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed timing cases, then
// randomized concurrent CPU/IO traffic against a word-array memory model.
module tb_mem_bus_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        wait_;
    logic [15:0] cpu_rdata;
    logic        io_req, io_we;
    logic [11:0] io_addr;
    logic [15:0] io_wdata;
    logic        io_gnt, io_done;
    logic [15:0] io_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    bit [15:0]   mem [4096];
    bit          written [4096];
    logic [15:0] ref_mem [4096];
    logic [15:0] cpu_exp, io_exp;
    logic [15:0] cpu_q[$];
    logic [15:0] io_q[$];
    bit          grants[$];
    bit          men_prev = 1'b0;

    mem_bus_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .wait_(wait_), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_gnt(io_gnt), .io_done(io_done),
        .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [11:0] a);
        logic [15:0] w;
        w = {4'b0, a};
        return (w * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Memory array: unwritten words hold a fixed address-derived pattern.
    assign mem_rdata = !mem_en ? 16'hDEAD :
                       written[mem_addr] ? mem[mem_addr] : pat(mem_addr);

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_req && !wait_) begin
                if (cpu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_ack_spurious: got ack expected none at %0t", $time);
                end else begin
                    chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
                end
            end
            if (io_done) begin
                if (io_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL io_done_spurious: got done expected none at %0t", $time);
                end else begin
                    chk("io_rdata", io_rdata, io_q.pop_front());
                end
            end
        end
        if (mem_en && !men_prev) grants.push_back(io_gnt);
        men_prev = mem_en;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_issue(input logic we, input logic [11:0] a,
                             input logic [15:0] d);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        if (we) ref_mem[a] = d;
        else cpu_exp = ref_mem[a];
        cpu_q.push_back(cpu_exp);
    endtask

    task automatic io_issue(input logic we, input logic [11:0] a,
                            input logic [15:0] d);
        io_we = we; io_addr = a; io_wdata = d; io_req = 1'b1;
        if (we) ref_mem[a] = d;
        else io_exp = ref_mem[a];
        io_q.push_back(io_exp);
    endtask

    task automatic cpu_wait();
        int lat = 0;
        bit done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            if (!wait_) done = 1'b1;
            else begin cyc(); lat++; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL cpu_timeout: got no ack expected ack within 100 cycles");
        end else begin
            chk("cpu_latency_ok", 32'(lat >= L + 1 && lat <= 2 * L + 3), 1);
        end
        cyc();
        cpu_req = 1'b0;
    endtask

    task automatic io_wait();
        int lat = 0;
        bit done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            if (io_done) done = 1'b1;
            else begin cyc(); lat++; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL io_timeout: got no done expected done within 100 cycles");
        end else begin
            chk("io_latency_ok", 32'(lat >= L + 1 && lat <= 2 * L + 3), 1);
        end
        cyc();
        io_req = 1'b0;
    endtask

    task automatic cpu_run(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) cyc();
            cpu_issue(1'($urandom), {8'h00, 4'($urandom)}, 16'($urandom));
            cpu_wait();
        end
    endtask

    task automatic io_run(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) cyc();
            io_issue(1'($urandom), {8'h80, 4'($urandom)}, 16'($urandom));
            io_wait();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        cpu_exp = '0;
        io_exp = '0;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int code;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(12'(i));
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
        cpu_exp = '0; io_exp = '0;

        // Reset state
        cyc(); cyc();
        @(negedge clk);
        chk("rst_ctrl", {mem_en, mem_we, io_gnt, io_done}, 0);
        chk("rst_mem", {mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {cpu_rdata, io_rdata}, 0);
        chk("rst_wait_lo", wait_, 0);
        cyc();
        cpu_req = 1'b1;
        @(negedge clk);
        chk("rst_wait_follows_req", wait_, 1);
        cyc();
        cpu_req = 1'b0;
        reset = 1'b0;
        cyc();
        @(negedge clk);
        chk("idle_outs", {wait_, mem_en, io_gnt, io_done}, 0);
        cyc();

        // CPU read timing (location pre-loaded through the port)
        cpu_issue(1'b1, 12'h012, 16'hBEEF);
        cpu_wait();
        cpu_issue(1'b0, 12'h012, 16'h0000);
        for (int c = 0; c <= L + 1; c++) begin
            @(negedge clk);
            chk("rd_mem_en", mem_en, 32'(c >= 1 && c <= L));
            if (c >= 1 && c <= L) chk("rd_mem_addr", mem_addr, 12'h012);
            chk("rd_wait", wait_, 32'(c <= L));
            if (c == L + 1) chk("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
            cyc();
        end
        cpu_req = 1'b0;
        cyc();

        // Tie right after reset: CPU first, then IO
        do_reset();
        cpu_issue(1'b0, 12'h012, 16'h0);
        io_issue(1'b0, 12'h800, 16'h0);
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            chk("tie_mem_en", mem_en, 32'(c == 1 || c == 2 || c == 5 || c == 6));
            chk("tie_io_gnt", io_gnt, 32'(c == 5 || c == 6));
            chk("tie_io_done", io_done, 32'(c == 7));
            chk("tie_wait", wait_, 32'(c <= 2));
            cyc();
            if (c == 3) cpu_req = 1'b0;
        end
        io_req = 1'b0;
        cyc(); cyc();

        // Both held: alternating grants
        grants.delete();
        cpu_issue(1'b0, 12'h012, 16'h0);
        cpu_issue(1'b0, 12'h012, 16'h0);
        io_issue(1'b0, 12'h800, 16'h0);
        repeat (12) cyc();
        cpu_req = 1'b0;
        io_req = 1'b0;
        cyc(); cyc();
        code = 0;
        foreach (grants[i]) code = code * 2 + int'(grants[i]);
        chk("rr_grant_cnt", grants.size(), 3);
        chk("rr_grant_order", code, 32'b010);

        // IO write
        io_issue(1'b1, 12'h0FF, 16'h1234);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            chk("wr_mem_we", mem_we, 32'(c == 1 || c == 2));
            if (c == 1 || c == 2) chk("wr_mem_wdata", mem_wdata, 16'h1234);
            if (c == 1 || c == 2) chk("wr_mem_addr", mem_addr, 12'h0FF);
            chk("wr_io_done", io_done, 32'(c == 3));
            chk("wr_io_rdata_kept", io_rdata, io_exp);
            cyc();
            if (c == 3) io_req = 1'b0;
        end
        cpu_issue(1'b0, 12'h0FF, 16'h0);
        cpu_wait();

        // Reset in the second access cycle aborts the access
        cpu_issue(1'b0, 12'h0FF, 16'h0);
        @(negedge clk); cyc();
        @(negedge clk); cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("ab_mem_en_before", mem_en, 1);
        cyc();
        @(negedge clk);
        chk("ab_mem_en_off", mem_en, 0);
        chk("ab_wait_held", wait_, 1);
        cyc();
        reset = 1'b0;
        io_exp = '0;
        // The retried read will reload cpu_rdata after the reset cleared it.
        cpu_exp = ref_mem[12'h0FF];
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk);
            chk("ab_retry_mem_en", mem_en, 32'(c == 5 || c == 6));
            chk("ab_retry_wait", wait_, 32'(c < 7));
            if (c == 7) chk("ab_retry_rdata", cpu_rdata, 16'h1234);
            cyc();
        end
        cpu_req = 1'b0;
        cyc();

        // Random concurrent traffic
        fork
            cpu_run(25);
            io_run(25);
        join
        repeat (5) cyc();
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("io_q_empty", io_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
